// File: rtl/imem_loader_if.sv
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream valid/ready channel feeding the program loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int dataWordSize = 8
) ();
  logic [dataWordSize-1:0] inByte;
  logic                    inValid;
  logic                    inReady;

  // Byte source (UART / debug bridge side)
  modport master (output inByte, output inValid, input inReady);
  // Byte sink (loader side)
  modport slave  (input inByte, input inValid, output inReady);
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Frame parser that assembles 16-bit words from a byte stream,
//                writes them into instruction memory and releases the CPU
//                only after a frame ends with a correct XOR checksum.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          ADDR_SIZE    = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          dataWordSize = 8
) (
  input  wire logic                 clock,
  input  wire logic                 rst,
  imem_loader_if.slave              bus,
  output      logic [ADDR_SIZE-1:0] iAddr,
  output      logic [15:0]          iData,
  output      logic                 iWrite,
  output      logic                 cpuHold,
  output      logic                 done,
  output      logic                 error
);

  typedef enum logic [3:0] {
    S_Sync  = 4'd0,
    S_Addr  = 4'd1,
    S_Count = 4'd2,
    S_DataH = 4'd3,
    S_DataL = 4'd4,
    S_Write = 4'd5,
    S_Check = 4'd6,
    S_Done  = 4'd7,
    S_Err   = 4'd8
  } state_t;

  state_t                 r_state,  w_nextState;
  logic [ADDR_SIZE-1:0]   r_iAddr,  w_iAddr;
  logic [15:0]            r_iData,  w_iData;
  logic [7:0]             r_chk,    w_chk;
  logic [8:0]             r_rem,    w_rem;
  logic                   r_hold,   w_hold;
  logic                   r_done,   w_done;
  logic                   r_err,    w_err;

  logic [dataWordSize-1:0] w_byte;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_isSync;

  // The only cycle that refuses bytes is the memory write cycle.
  assign w_ready  = (r_state != S_Write);
  assign w_accept = bus.inValid && w_ready;
  assign w_byte   = bus.inByte;
  assign w_isSync = (w_byte == SYNC_BYTE);

  assign bus.inReady = w_ready;
  assign iAddr       = r_iAddr;
  assign iData       = r_iData;
  assign iWrite      = (r_state == S_Write);
  assign cpuHold     = r_hold;
  assign done        = r_done;
  assign error       = r_err;

  // Next-state, datapath and status decode; everything holds by default.
  always_comb begin
    w_nextState = r_state;
    w_iAddr     = r_iAddr;
    w_iData     = r_iData;
    w_chk       = r_chk;
    w_rem       = r_rem;
    w_hold      = r_hold;
    w_done      = r_done;
    w_err       = r_err;
    case (r_state)
      // Sync, Done and Err all restart on the marker and drop anything else.
      S_Sync, S_Done, S_Err: begin
        if (w_accept && w_isSync) begin
          w_nextState = S_Addr;
          w_hold      = 1'b1;
          w_done      = 1'b0;
          w_err       = 1'b0;
          w_chk       = 8'h00;
        end
      end
      S_Addr: begin
        if (w_accept) begin
          w_iAddr     = ADDR_SIZE'(w_byte);
          w_chk       = r_chk ^ w_byte;
          w_nextState = S_Count;
        end
      end
      S_Count: begin
        if (w_accept) begin
          w_rem       = (w_byte == 8'h00) ? 9'd256 : {1'b0, w_byte};
          w_chk       = r_chk ^ w_byte;
          w_nextState = S_DataH;
        end
      end
      S_DataH: begin
        if (w_accept) begin
          w_iData     = {w_byte, r_iData[7:0]};
          w_chk       = r_chk ^ w_byte;
          w_nextState = S_DataL;
        end
      end
      S_DataL: begin
        if (w_accept) begin
          w_iData     = {r_iData[15:8], w_byte};
          w_chk       = r_chk ^ w_byte;
          w_nextState = S_Write;
        end
      end
      // Address/data are presented unchanged this cycle; advance afterwards.
      S_Write: begin
        w_iAddr     = r_iAddr + ADDR_SIZE'(1);
        w_rem       = r_rem - 9'd1;
        w_nextState = (r_rem == 9'd1) ? S_Check : S_DataH;
      end
      S_Check: begin
        if (w_accept) begin
          if (w_byte == r_chk) begin
            w_nextState = S_Done;
            w_done      = 1'b1;
            w_hold      = 1'b0;
          end else begin
            w_nextState = S_Err;
            w_err       = 1'b1;
            w_hold      = 1'b1;
          end
        end
      end
      default: w_nextState = S_Sync;
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= S_Sync;
      r_iAddr <= '0;
      r_iData <= 16'h0000;
      r_chk   <= 8'h00;
      r_rem   <= 9'd0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_iAddr <= w_iAddr;
      r_iData <= w_iData;
      r_chk   <= w_chk;
      r_rem   <= w_rem;
      r_hold  <= w_hold;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader with randomized stalls.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clock = 1'b0;
  logic        rst;
  logic [7:0]  iAddr;
  logic [15:0] iData;
  logic        iWrite, cpuHold, done, error;

  imem_loader_if #(.dataWordSize(8)) bus ();

  imem_loader #(.ADDR_SIZE(8), .SYNC_BYTE(8'hA5), .dataWordSize(8)) dut (
    .clock   (clock),
    .rst     (rst),
    .bus     (bus),
    .iAddr   (iAddr),
    .iData   (iData),
    .iWrite  (iWrite),
    .cpuHold (cpuHold),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Monitor-owned record of observed writes and handshake consistency.
  int          wr_cnt  = 0;
  int          rdy_bad = 0;
  logic [7:0]  mon_a [4096];
  logic [15:0] mon_d [4096];
  int          mon_c [4096];

  logic [15:0] fw [256];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rst === 1'b0) begin
      if (bus.inReady === iWrite) rdy_bad <= rdy_bad + 1;
      if (iWrite === 1'b1 && wr_cnt < 4096) begin
        mon_a[wr_cnt] <= iAddr;
        mon_d[wr_cnt] <= iData;
        mon_c[wr_cnt] <= cyc;
        wr_cnt        <= wr_cnt + 1;
      end
    end
  end

  // Reference checksum: XOR of header bytes and every data byte.
  function automatic logic [7:0] model_chk(input logic [7:0] sa, input logic [7:0] cnt);
    int n;
    logic [7:0] x;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    x = sa ^ cnt;
    for (int i = 0; i < n; i++) x = x ^ fw[i][15:8] ^ fw[i][7:0];
    return x;
  endfunction

  // Offer one byte after an optional stall; returns the cycle the write
  // following this byte (if it is a low byte) must appear in.
  task automatic send_byte(input logic [7:0] b, input int maxstall, output int acc_cyc);
    int  st;
    int  c;
    bit  rdy;
    st = (maxstall > 0) ? int'($urandom_range(maxstall, 0)) : 0;
    repeat (st) begin
      @(negedge clock);
      bus.inValid = 1'b0;
    end
    @(negedge clock);
    bus.inValid = 1'b1;
    bus.inByte  = b;
    for (int k = 0; k < 20; k++) begin
      rdy = bus.inReady;
      c   = cyc;
      @(posedge clock);
      if (rdy) begin
        acc_cyc = c + 1;
        return;
      end
      @(negedge clock);
    end
    checks++; errors++;
    $display("FAIL handshake_timeout: inReady stayed 0, byte %02h not accepted", b);
    acc_cyc = -1;
  endtask

  // Send one full frame from fw[] and verify writes, latency and status.
  task automatic run_frame(input string name, input logic [7:0] sa, input logic [7:0] cnt,
                           input logic [7:0] chk, input int maxstall);
    int n, base, a;
    int exp_c [$];
    bit ok;
    n    = (cnt == 8'd0) ? 256 : int'(cnt);
    ok   = (chk == model_chk(sa, cnt));
    base = wr_cnt;
    send_byte(8'hA5, maxstall, a);
    send_byte(sa,    maxstall, a);
    send_byte(cnt,   maxstall, a);
    for (int i = 0; i < n; i++) begin
      send_byte(fw[i][15:8], maxstall, a);
      send_byte(fw[i][7:0],  maxstall, a);
      exp_c.push_back(a);
    end
    send_byte(chk, maxstall, a);
    @(negedge clock);
    bus.inValid = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (wr_cnt - base !== n) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_cnt - base, n);
    end
    for (int i = 0; i < n && base + i < wr_cnt; i++) begin
      checks++;
      if (mon_a[base+i] !== 8'(int'(sa) + i) || mon_d[base+i] !== fw[i] ||
          mon_c[base+i] !== exp_c[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got a=%02h d=%04h cyc=%0d expected a=%02h d=%04h cyc=%0d",
                 name, i, mon_a[base+i], mon_d[base+i], mon_c[base+i],
                 8'(int'(sa) + i), fw[i], exp_c[i]);
      end
    end
    checks++;
    if ({done, error, cpuHold, iWrite, bus.inReady} !== {ok, !ok, !ok, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s status: got done=%b error=%b hold=%b wr=%b rdy=%b expected done=%b error=%b hold=%b wr=0 rdy=1",
               name, done, error, cpuHold, iWrite, bus.inReady, ok, !ok, !ok);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    bus.inValid = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.inValid = 1'b0;
    bus.inByte  = 8'h00;
    repeat (2) @(negedge clock);
    checks++;
    if ({iAddr, iData, iWrite, bus.inReady, cpuHold, done, error} !==
        {8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got a=%02h d=%04h wr=%b rdy=%b hold=%b done=%b err=%b expected 00 0000 0 1 1 0 0",
               iAddr, iData, iWrite, bus.inReady, cpuHold, done, error);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int base;
    base = wr_cnt;
    fw[0] = 16'h8801; fw[1] = 16'h1234;
    run_frame("basic", 8'h10, 8'h02, 8'hBD, 0);
    checks++;
    if (mon_a[base] !== 8'h10 || mon_d[base] !== 16'h8801 ||
        mon_a[base+1] !== 8'h11 || mon_d[base+1] !== 16'h1234) begin
      errors++;
      $display("FAIL basic_literal: got %02h:%04h %02h:%04h expected 10:8801 11:1234",
               mon_a[base], mon_d[base], mon_a[base+1], mon_d[base+1]);
    end
  endtask

  task automatic test_bad_checksum();
    fw[0] = 16'h8801; fw[1] = 16'h1234;
    run_frame("bad_chk", 8'h10, 8'h02, 8'hBC, 0);
    checks++;
    if ({error, done, cpuHold} !== 3'b101) begin
      errors++;
      $display("FAIL bad_chk_literal: got error=%b done=%b hold=%b expected 1 0 1", error, done, cpuHold);
    end
    run_frame("reload", 8'h10, 8'h02, 8'hBD, 1);
  endtask

  task automatic test_leading_garbage();
    int a;
    int base;
    pulse_reset();
    base = wr_cnt;
    send_byte(8'h00, 0, a);
    send_byte(8'hFF, 0, a);
    send_byte(8'h3C, 0, a);
    fw[0] = 16'hABCD;
    run_frame("garbage", 8'h00, 8'h01, 8'h67, 0);
    checks++;
    if (mon_a[base] !== 8'h00 || mon_d[base] !== 16'hABCD || done !== 1'b1) begin
      errors++;
      $display("FAIL garbage_literal: got %02h:%04h done=%b expected 00:ABCD done=1",
               mon_a[base], mon_d[base], done);
    end
  endtask

  task automatic test_addr_wrap();
    int base;
    base = wr_cnt;
    fw[0] = 16'h1111; fw[1] = 16'h2222;
    run_frame("wrap", 8'hFF, 8'h02, 8'hFD, 2);
    checks++;
    if (mon_a[base] !== 8'hFF || mon_a[base+1] !== 8'h00) begin
      errors++;
      $display("FAIL wrap_literal: got %02h then %02h expected FF then 00", mon_a[base], mon_a[base+1]);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] sa, cnt, chk;
    for (int f = 0; f < 8; f++) begin
      sa  = 8'($urandom);
      cnt = 8'($urandom_range(8, 1));
      for (int i = 0; i < 256; i++) fw[i] = 16'($urandom);
      chk = model_chk(sa, cnt);
      if ($urandom_range(2, 0) == 0) chk = chk ^ 8'(1 << $urandom_range(7, 0));
      run_frame("random", sa, cnt, chk, (f % 2 == 0) ? 0 : 3);
    end
    for (int i = 0; i < 256; i++) fw[i] = 16'($urandom);
    run_frame("count256", 8'h80, 8'h00, model_chk(8'h80, 8'h00), 0);
    checks++;
    if (rdy_bad !== 0) begin
      errors++;
      $display("FAIL ready_vs_write: %0d cycles with inReady==iWrite, expected 0", rdy_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int a;
    int base;
    send_byte(8'hA5, 0, a);
    send_byte(8'h20, 0, a);
    send_byte(8'h03, 0, a);
    send_byte(8'h55, 0, a);
    @(negedge clock);
    bus.inValid = 1'b0;
    base = wr_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({iAddr, iData, iWrite, bus.inReady, cpuHold, done, error} !==
        {8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values: got a=%02h d=%04h wr=%b rdy=%b hold=%b done=%b err=%b expected 00 0000 0 1 1 0 0",
               iAddr, iData, iWrite, bus.inReady, cpuHold, done, error);
    end
    @(negedge clock);
    rst = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (wr_cnt !== base || cpuHold !== 1'b1) begin
      errors++;
      $display("FAIL midreset_nowrite: got writes=%0d hold=%b expected writes=0 hold=1", wr_cnt - base, cpuHold);
    end
    fw[0] = 16'hCAFE; fw[1] = 16'hBEEF; fw[2] = 16'h0123;
    run_frame("after_reset", 8'h40, 8'h03, model_chk(8'h40, 8'h03), 1);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_checksum();
    test_leading_garbage();
    test_addr_wrap();
    test_random_stream();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that is the writing end of instruction memory; the CPU controller is the reading end, fetching through IR.
- Accepts a framed byte stream over a valid/ready handshake (from the UART/debug bridge) and assembles 16-bit instruction words.
- Writes those words into instruction memory through its write port.
- Holds the CPU in reset until a load finishes with a correct checksum.

Parameters:
ADDR_SIZE, 8, instruction memory address width
SYNC_BYTE, 8'hA5, frame start marker
dataWordSize, 8, input byte width

Ports:
clock  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
inByte  input  8  stream byte
inValid  input  1  inByte valid
inReady  output  1  loader can accept a byte this cycle
iAddr  output  ADDR_SIZE  instruction memory write address
iData  output  16  instruction word to write
iWrite  output  1  instruction memory write strobe, one cycle per word
cpuHold  output  1  1 = keep CPU controller in reset; drives the controller's nRst through an inverter
done  output  1  last frame loaded and checksum correct
error  output  1  last frame checksum mismatch

Behaviour:
- Handshake: a byte is accepted on a rising clock edge where inValid=1 and inReady=1. Nothing is consumed otherwise. inValid may stall any number of cycles.
- Reset values: state=S_Sync, inReady=1, iAddr=0, iData=0, iWrite=0, cpuHold=1, done=0, error=0, checksum=0, remaining=0.
- Frame format: SYNC_BYTE, startAddr, count, then count words each sent high byte then low byte, then chk.
  - count=0 means 256 words.
  - chk = XOR of startAddr, count and every data byte. SYNC_BYTE is excluded.
- States:
  - S_Sync: accepted byte == SYNC_BYTE -> S_Addr; set cpuHold=1, clear done/error, clear checksum. Any other byte is discarded; stay.
  - S_Addr: accept -> iAddr=byte (zero-extended/truncated to ADDR_SIZE), checksum^=byte -> S_Count.
  - S_Count: accept -> remaining=(byte==0)?256:byte (9-bit), checksum^=byte -> S_DataH.
  - S_DataH: accept -> iData[15:8]=byte, checksum^=byte -> S_DataL.
  - S_DataL: accept -> iData[7:0]=byte, checksum^=byte -> S_Write.
  - S_Write: one cycle. iWrite=1 with registered iAddr/iData; inReady=0. At the end of the cycle, iAddr+=1 (wraps modulo 2^ADDR_SIZE) and remaining-=1. remaining was 1 -> S_Check, else -> S_DataH.
  - S_Check: accept -> byte==checksum ? S_Done : S_Err.
  - S_Done: done=1, cpuHold=0. A SYNC_BYTE restarts as in S_Sync; other bytes are discarded.
  - S_Err: error=1, cpuHold=1. A SYNC_BYTE restarts; other bytes are discarded.
- inReady=1 in every state except S_Write.
- iWrite is high only in S_Write. Latency is exactly one cycle from the accept edge of a low byte to the iWrite cycle.
- iAddr and iData are stable for the whole iWrite cycle.
- Words already written before a checksum failure stay in memory. cpuHold stays 1, so the CPU never runs a partially or incorrectly loaded image.
- A SYNC_BYTE in the middle of a frame is data, not a restart. There is no resync except by reset.
- Reset asserted during a frame: immediate return to reset values. cpuHold=1 and no further writes occur.
- cpuHold, done and error are registered outputs. done and error are never both 1.

Test Plan:
- Reset, then send A5 10 02 88 01 12 34 BD -> iWrite at addr 0x10 with data 0x8801 and at addr 0x11 with data 0x1234; each write one cycle after its low byte is accepted. Then done=1, cpuHold=0, error=0.
- Same frame with chk=0xBC -> two writes still occur; error=1, done=0, cpuHold=1. Then send the correct frame -> done=1, cpuHold=0.
- Send 00 FF 3C, then A5 00 01 AB CD chk=0x67 -> leading bytes are ignored; a single write of 0xABCD at addr 0x00; done=1.
- Start addr 0xFF, count 0x02, words 0x1111 and 0x2222, chk=0xFD -> writes at 0xFF then 0x00 (wrap); done=1.
- Toggle inValid randomly and also send back-to-back bytes -> inReady is 0 only in write cycles; no byte is lost or duplicated; the write count equals count.
- Assert rst for one cycle after the first data byte -> outputs return to reset values, no iWrite occurs, cpuHold=1, and the next full frame loads correctly.
